chacha_stream_ctrl: RTL and testbench

CHACHA_STREAM_CTRL -- requirements
Module: chacha_stream_ctrl

---
 rtl/chacha_stream_ctrl_if.sv | 25 ++
 rtl/chacha_stream_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_chacha_stream_ctrl.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chacha_stream_ctrl_if.sv
// Stream and register-bus signals between the ChaCha stream controller and its environment.
// The controller binds to the master modport; sources, sinks and the peripheral use slave.
interface chacha_stream_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        m_cs;
  logic        m_we;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  modport master (
    input  in_valid, in_data, out_ready, m_rdata,
    output in_ready, out_valid, out_data, m_cs, m_we, m_addr, m_wdata
  );

  modport slave (
    output in_valid, in_data, out_ready, m_rdata,
    input  in_ready, out_valid, out_data, m_cs, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/chacha_stream_ctrl.sv
// Sequences a memory-mapped ChaCha core: programs key/IV once per stream, then per block
// loads 16 plaintext words, kicks init/next, polls for completion and drains 16 cipher words.
module chacha_stream_ctrl #(
  parameter logic [4:0] ROUNDS = 5'd20,
  parameter logic       KEYLEN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cfg_start,
  input  logic [255:0]         cfg_key,
  input  logic [63:0]          cfg_iv,
  output logic                 busy,
  output logic [31:0]          blk_cnt,
  chacha_stream_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CFG    = 3'd1,
    LOAD   = 3'd2,
    KICK   = 3'd3,
    SETTLE = 3'd4,
    POLL   = 3'd5,
    DRAIN  = 3'd6
  } state_t;

  state_t        state_r;
  logic [255:0]  key_r;
  logic [63:0]   iv_r;
  logic [3:0]    idx_r;
  logic [3:0]    cfg_cnt_r;
  logic          settle_r;
  logic          first_blk_r;
  logic [15:0]   poll_cnt_r;
  logic [31:0]   blk_cnt_r;
  logic          out_valid_r;
  logic [31:0]   out_data_r;
  logic          in_ready_r;
  logic          busy_r;
  logic          cs_r;
  logic          we_r;
  logic [7:0]    addr_r;
  logic [31:0]   wdata_r;

  logic          load_wr_s;
  logic          m_cs_s;
  logic          m_we_s;
  logic [7:0]    m_addr_s;
  logic [31:0]   m_wdata_s;

  // Configuration write n: 0x0a, 0x0b, key words at 0x10..0x17, IV words at 0x20..0x21.
  function automatic logic [7:0] cfg_addr(input logic [3:0] n);
    logic [7:0] a;
    logic [2:0] k;
    k = 3'(n - 4'd2);
    case (n)
      4'd0:                                           a = 8'h0a;
      4'd1:                                           a = 8'h0b;
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: a = {5'b00010, k};
      4'd10, 4'd11:                                   a = {7'b0010000, n[0]};
      default:                                        a = 8'h00;
    endcase
    return a;
  endfunction

  function automatic logic [31:0] cfg_data(input logic [3:0] n, input logic [255:0] key,
                                           input logic [63:0] iv);
    logic [31:0] d;
    logic [2:0]  k;
    k = 3'(n - 4'd2);
    case (n)
      4'd0:                                           d = {31'd0, KEYLEN};
      4'd1:                                           d = {27'd0, ROUNDS};
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: d = 32'(key >> {~k, 5'd0});
      4'd10:                                          d = iv[63:32];
      4'd11:                                          d = iv[31:0];
      default:                                        d = 32'd0;
    endcase
    return d;
  endfunction

  // Main sequencer; bus outputs are registered one cycle ahead of the state that owns them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      key_r       <= 256'd0;
      iv_r        <= 64'd0;
      idx_r       <= 4'd0;
      cfg_cnt_r   <= 4'd0;
      settle_r    <= 1'b0;
      first_blk_r <= 1'b0;
      poll_cnt_r  <= 16'd0;
      blk_cnt_r   <= 32'd0;
      out_valid_r <= 1'b0;
      out_data_r  <= 32'd0;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      cs_r        <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= 8'd0;
      wdata_r     <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cfg_start) begin
            key_r       <= cfg_key;
            iv_r        <= cfg_iv;
            blk_cnt_r   <= 32'd0;
            first_blk_r <= 1'b1;
            idx_r       <= 4'd0;
            cfg_cnt_r   <= 4'd0;
            busy_r      <= 1'b1;
            state_r     <= CFG;
            cs_r        <= 1'b1;
            we_r        <= 1'b1;
            addr_r      <= cfg_addr(4'd0);
            wdata_r     <= cfg_data(4'd0, cfg_key, cfg_iv);
          end
        end
        CFG: begin
          if (cfg_cnt_r == 4'd11) begin
            cs_r       <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= 8'd0;
            wdata_r    <= 32'd0;
            in_ready_r <= 1'b1;
            state_r    <= LOAD;
          end else begin
            cfg_cnt_r <= cfg_cnt_r + 4'd1;
            addr_r    <= cfg_addr(cfg_cnt_r + 4'd1);
            wdata_r   <= cfg_data(cfg_cnt_r + 4'd1, key_r, iv_r);
          end
        end
        LOAD: begin
          // The data write itself is combinational; only the word index advances here.
          if (bus.in_valid) begin
            idx_r <= idx_r + 4'd1;
            if (idx_r == 4'd15) begin
              in_ready_r <= 1'b0;
              state_r    <= KICK;
              cs_r       <= 1'b1;
              we_r       <= 1'b1;
              addr_r     <= 8'h08;
              wdata_r    <= first_blk_r ? 32'h0000_0001 : 32'h0000_0002;
            end
          end
        end
        KICK: begin
          first_blk_r <= 1'b0;
          cs_r        <= 1'b0;
          we_r        <= 1'b0;
          addr_r      <= 8'd0;
          wdata_r     <= 32'd0;
          settle_r    <= 1'b0;
          state_r     <= SETTLE;
        end
        SETTLE: begin
          if (settle_r) begin
            cs_r       <= 1'b1;
            addr_r     <= 8'h09;
            poll_cnt_r <= 16'd0;
            state_r    <= POLL;
          end else begin
            settle_r <= 1'b1;
          end
        end
        POLL: begin
          if (bus.m_rdata[1:0] == 2'b11) begin
            addr_r  <= {4'h8, idx_r};
            state_r <= DRAIN;
          end else if (poll_cnt_r != 16'hFFFF) begin
            poll_cnt_r <= poll_cnt_r + 16'd1;
          end
        end
        DRAIN: begin
          if (cs_r) begin
            out_data_r  <= bus.m_rdata;
            out_valid_r <= 1'b1;
            idx_r       <= idx_r + 4'd1;
            cs_r        <= 1'b0;
            addr_r      <= 8'd0;
          end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
            // idx has wrapped to 0 only after the sixteenth read of the block.
            if (idx_r == 4'd0) begin
              blk_cnt_r  <= blk_cnt_r + 32'd1;
              in_ready_r <= 1'b1;
              state_r    <= LOAD;
            end else begin
              cs_r   <= 1'b1;
              addr_r <= {4'h8, idx_r};
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Merge the registered bus access with the same-cycle plaintext write during LOAD.
  always_comb begin
    load_wr_s = in_ready_r & bus.in_valid;
    if (load_wr_s) begin
      m_cs_s    = 1'b1;
      m_we_s    = 1'b1;
      m_addr_s  = {4'h4, idx_r};
      m_wdata_s = bus.in_data;
    end else begin
      m_cs_s    = cs_r;
      m_we_s    = we_r;
      m_addr_s  = addr_r;
      m_wdata_s = wdata_r;
    end
  end

  assign bus.m_cs      = m_cs_s;
  assign bus.m_we      = m_we_s;
  assign bus.m_addr    = m_addr_s;
  assign bus.m_wdata   = m_wdata_s;
  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign busy          = busy_r;
  assign blk_cnt       = blk_cnt_r;

endmodule

// File: tb/tb_chacha_stream_ctrl.sv
// Bench for chacha_stream_ctrl: a behavioural ChaCha register peripheral plus a scoreboard
// of expected ciphertext computed from the bench's own key, IV, counter and plaintext.
module tb_chacha_stream_ctrl;
  logic         clk;
  logic         reset_n;
  logic         cfg_start;
  logic [255:0] cfg_key;
  logic [63:0]  cfg_iv;
  logic         busy;
  logic [31:0]  blk_cnt;

  chacha_stream_ctrl_if bus_if ();

  chacha_stream_ctrl dut (
    .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_key(cfg_key),
    .cfg_iv(cfg_iv), .busy(busy), .blk_cnt(blk_cnt), .bus(bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] ai, bi, ci, di);
    logic [31:0] a, b, c, d;
    a = ai; b = bi; c = ci; d = di;
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  // Serialised keystream block, word 0 in the top bits, each word read big-endian from the byte stream.
  function automatic logic [511:0] ks_block(input logic [255:0] key, input logic [63:0] iv,
                                            input logic [63:0] ctr, input int rounds);
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [255:0] kt;
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    kt = key;
    for (int k = 0; k < 8; k++) begin
      s[4 + k] = bswap(kt[255:224]);
      kt = kt << 32;
    end
    s[12] = ctr[31:0]; s[13] = ctr[63:32];
    s[14] = bswap(iv[63:32]); s[15] = bswap(iv[31:0]);
    x = s;
    for (int i = 0; i < rounds / 2; i++) begin
      {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
    end
    r = 512'd0;
    for (int i = 0; i < 16; i++) r = {r[479:0], bswap(x[i] + s[i])};
    return r;
  endfunction

  function automatic logic [31:0] ks_word(input logic [511:0] ks, input logic [3:0] i);
    return 32'(ks >> {~i, 5'd0});
  endfunction

  function automatic logic [39:0] exp_cfg(input int i, input logic [255:0] key, input logic [63:0] iv);
    logic [255:0] kt;
    kt = key << (32 * (i - 2));
    if (i == 0) return {8'h0a, 32'd1};
    else if (i == 1) return {8'h0b, 32'd20};
    else if (i < 10) return {8'h10 + 8'(i - 2), kt[255:224]};
    else if (i == 10) return {8'h20, iv[63:32]};
    else return {8'h21, iv[31:0]};
  endfunction

  // ---------------- behavioural ChaCha peripheral ----------------
  logic [31:0]  p_key [8];
  logic [31:0]  p_iv [2];
  logic [31:0]  p_din [16];
  logic [4:0]   p_rounds = 5'd0;
  logic [63:0]  p_ctr = 64'd0;
  logic [511:0] p_ks = 512'd0;
  logic         p_valid = 1'b0;
  logic [7:0]   p_busy = 8'd0;
  int           cyc = 0;
  int           rd_cnt = 0;
  int           kick_cnt = 0;
  logic [31:0]  last_kick = 32'd0;
  logic [7:0]   wr_addr_q [$];
  logic [31:0]  wr_data_q [$];
  int           wr_cyc_q [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (p_busy != 8'd0) p_busy <= p_busy - 8'd1;
    if (bus_if.m_cs && !bus_if.m_we) rd_cnt <= rd_cnt + 1;
    if (bus_if.m_cs && bus_if.m_we) begin
      wr_addr_q.push_back(bus_if.m_addr);
      wr_data_q.push_back(bus_if.m_wdata);
      wr_cyc_q.push_back(cyc);
      if (bus_if.m_addr == 8'h0b) p_rounds <= bus_if.m_wdata[4:0];
      else if (bus_if.m_addr[7:3] == 5'b00010) p_key[bus_if.m_addr[2:0]] <= bus_if.m_wdata;
      else if (bus_if.m_addr[7:1] == 7'b0010000) p_iv[bus_if.m_addr[0]] <= bus_if.m_wdata;
      else if (bus_if.m_addr[7:4] == 4'h4) p_din[bus_if.m_addr[3:0]] <= bus_if.m_wdata;
      else if (bus_if.m_addr == 8'h08) begin
        kick_cnt  <= kick_cnt + 1;
        last_kick <= bus_if.m_wdata;
        p_busy    <= 8'd6;
        p_valid   <= 1'b1;
        if (bus_if.m_wdata == 32'd1) begin
          p_ctr <= 64'd0;
          p_ks  <= ks_block({p_key[0], p_key[1], p_key[2], p_key[3], p_key[4], p_key[5], p_key[6], p_key[7]},
                            {p_iv[0], p_iv[1]}, 64'd0, int'(p_rounds));
        end else begin
          p_ctr <= p_ctr + 64'd1;
          p_ks  <= ks_block({p_key[0], p_key[1], p_key[2], p_key[3], p_key[4], p_key[5], p_key[6], p_key[7]},
                            {p_iv[0], p_iv[1]}, p_ctr + 64'd1, int'(p_rounds));
        end
      end
    end
  end

  always_comb begin
    bus_if.m_rdata = 32'd0;
    if (bus_if.m_cs && !bus_if.m_we) begin
      if (bus_if.m_addr == 8'h09)
        bus_if.m_rdata = {30'd0, p_busy == 8'd0, (p_busy == 8'd0) && p_valid};
      else if (bus_if.m_addr[7:4] == 4'h8)
        bus_if.m_rdata = ks_word(p_ks, bus_if.m_addr[3:0]) ^ p_din[bus_if.m_addr[3:0]];
    end
  end

  // ---------------- scoreboard ----------------
  logic [255:0] tb_key;
  logic [63:0]  tb_iv;
  logic [31:0]  blk_in [16];
  logic [31:0]  got [16];
  logic [31:0]  exp_q [$];

  task automatic push_expected(input logic [63:0] ctr);
    logic [511:0] ks;
    ks = ks_block(tb_key, tb_iv, ctr, 20);
    for (int i = 0; i < 16; i++) exp_q.push_back(ks_word(ks, 4'(i)) ^ blk_in[i]);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) blk_in[i] = $urandom;
  endtask

  task automatic send_block();
    int tmo;
    for (int i = 0; i < 16; i++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = blk_in[i];
      tmo = 0;
      while (!bus_if.in_ready && tmo < 100) begin @(negedge clk); tmo++; end
      if (tmo >= 100) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout word %0d: in_ready stayed 0, required 1", i);
        bus_if.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    bus_if.in_valid = 1'b0;
  endtask

  task automatic receive_block(input int stall_word, input bit junk);
    int          tmo;
    int          rd0;
    logic [31:0] held;
    logic [31:0] ev;
    for (int k = 0; k < 16; k++) begin
      tmo = 0;
      while (!bus_if.out_valid && tmo < 200) begin @(negedge clk); tmo++; end
      if (tmo >= 200) begin
        n_cmp++; n_bad++;
        $display("FAIL recv_timeout word %0d: out_valid stayed 0, required 1", k);
        bus_if.in_valid = 1'b0;
        return;
      end
      if (junk && k == 0) begin bus_if.in_valid = 1'b1; bus_if.in_data = 32'hdead_beef; end
      if (junk && k == 15) bus_if.in_valid = 1'b0;
      if (k == stall_word) begin
        bus_if.out_ready = 1'b0;
        held = bus_if.out_data;
        rd0  = rd_cnt;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          n_cmp++;
          if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== held || bus_if.m_cs !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_hold cycle %0d: valid=%b data=%h cs=%b, required valid=1 data=%h cs=0",
                     c, bus_if.out_valid, bus_if.out_data, bus_if.m_cs, held);
          end
        end
        n_cmp++;
        if (rd_cnt !== rd0) begin
          n_bad++;
          $display("FAIL stall_reads: %0d reads during stall, required 0", rd_cnt - rd0);
        end
        bus_if.out_ready = 1'b1;
      end
      ev = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      got[k] = bus_if.out_data;
      n_cmp++;
      if (bus_if.out_data !== ev) begin
        n_bad++;
        $display("FAIL out_word %0d: got %h, required %h", k, bus_if.out_data, ev);
      end
      @(negedge clk);
    end
  endtask

  task automatic start_stream(input logic [255:0] key, input logic [63:0] iv);
    int tmo;
    tb_key = key; tb_iv = iv;
    cfg_key = key; cfg_iv = iv;
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    tmo = 0;
    while (!bus_if.in_ready && tmo < 50) begin @(negedge clk); tmo++; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, bus_if.in_ready, bus_if.out_valid, bus_if.m_cs, bus_if.m_we} !== 5'b0 ||
        blk_cnt !== 32'd0 || bus_if.out_data !== 32'd0 || bus_if.m_addr !== 8'd0 || bus_if.m_wdata !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b rdy=%b ov=%b cs=%b we=%b blk=%h od=%h, required all 0",
               busy, bus_if.in_ready, bus_if.out_valid, bus_if.m_cs, bus_if.m_we, blk_cnt, bus_if.out_data);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || bus_if.m_cs !== 1'b0 || bus_if.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: busy=%b cs=%b rdy=%b, required 0 0 0", busy, bus_if.m_cs, bus_if.in_ready);
    end
  endtask

  task automatic test_config();
    logic [39:0] e;
    start_stream(256'd0, 64'd0);
    n_cmp++;
    if (wr_addr_q.size() != 12 || bus_if.in_ready !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL cfg_count: %0d writes rdy=%b busy=%b, required 12 writes rdy=1 busy=1",
               wr_addr_q.size(), bus_if.in_ready, busy);
    end
    for (int i = 0; i < 12 && i < wr_addr_q.size(); i++) begin
      e = exp_cfg(i, tb_key, tb_iv);
      n_cmp++;
      if (wr_addr_q[i] !== e[39:32] || wr_data_q[i] !== e[31:0] || wr_cyc_q[i] != wr_cyc_q[0] + i) begin
        n_bad++;
        $display("FAIL cfg_write %0d: addr %h data %h cyc+%0d, required addr %h data %h cyc+%0d",
                 i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i] - wr_cyc_q[0], e[39:32], e[31:0], i);
      end
    end
  endtask

  task automatic test_known_answer();
    int k0;
    k0 = kick_cnt;
    for (int i = 0; i < 16; i++) blk_in[i] = 32'd0;
    push_expected(64'd0);
    send_block();
    receive_block(-1, 1'b0);
    n_cmp++;
    if (kick_cnt - k0 != 1 || last_kick !== 32'h1) begin
      n_bad++;
      $display("FAIL kat_kick: %0d kicks value %h, required 1 kick value 00000001", kick_cnt - k0, last_kick);
    end
    n_cmp++;
    if (got[0] !== 32'h76b8e0ad || got[1] !== 32'ha0f13d90) begin
      n_bad++;
      $display("FAIL kat_words: got %h %h, required 76b8e0ad a0f13d90", got[0], got[1]);
    end
    n_cmp++;
    if (blk_cnt !== 32'd1) begin n_bad++; $display("FAIL kat_blk_cnt: got %0d, required 1", blk_cnt); end
  endtask

  task automatic test_second_block();
    fill_random();
    push_expected(64'd1);
    send_block();
    receive_block(-1, 1'b0);
    n_cmp++;
    if (last_kick !== 32'h2 || blk_cnt !== 32'd2) begin
      n_bad++;
      $display("FAIL next_block: kick %h blk_cnt %0d, required kick 00000002 blk_cnt 2", last_kick, blk_cnt);
    end
  endtask

  task automatic test_backpressure();
    fill_random();
    push_expected(64'd2);
    send_block();
    receive_block(5, 1'b0);
    n_cmp++;
    if (blk_cnt !== 32'd3 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL bp_block: blk_cnt %0d left %0d, required blk_cnt 3 left 0", blk_cnt, exp_q.size());
    end
  endtask

  task automatic test_ignored_inputs();
    int tmo;
    int nwr;
    fill_random();
    push_expected(64'd3);
    send_block();
    tmo = 0;
    while (!(bus_if.m_cs && !bus_if.m_we && bus_if.m_addr == 8'h09) && tmo < 100) begin @(negedge clk); tmo++; end
    n_cmp++;
    if (tmo >= 100) begin n_bad++; $display("FAIL poll_seen: no status read, required read of 09"); end
    nwr = wr_addr_q.size();
    cfg_key = {8{32'h5a5a_1234}};
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    receive_block(-1, 1'b1);
    n_cmp++;
    if (wr_addr_q.size() != nwr || blk_cnt !== 32'd4 || busy !== 1'b1 || bus_if.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ignored_inputs: %0d extra writes blk_cnt %0d busy %b rdy %b, required 0 4 1 1",
               wr_addr_q.size() - nwr, blk_cnt, busy, bus_if.in_ready);
    end
  endtask

  task automatic test_reset_mid_drain();
    int tmo;
    int rd0;
    fill_random();
    push_expected(64'd4);
    send_block();
    tmo = 0;
    while (!bus_if.out_valid && tmo < 200) begin @(negedge clk); tmo++; end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (bus_if.out_valid !== 1'b0 || bus_if.m_cs !== 1'b0 || busy !== 1'b0 || blk_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL async_reset: ov=%b cs=%b busy=%b blk=%0d, required 0 0 0 0",
               bus_if.out_valid, bus_if.m_cs, busy, blk_cnt);
    end
    exp_q.delete();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    rd0 = rd_cnt;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (wr_addr_q.size() != 0 || rd_cnt != rd0 || busy !== 1'b0 || bus_if.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_idle: %0d writes %0d reads busy=%b rdy=%b, required 0 0 0 0",
               wr_addr_q.size(), rd_cnt - rd0, busy, bus_if.in_ready);
    end
  endtask

  task automatic test_restart();
    logic [39:0] e;
    int          k0;
    start_stream({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom});
    n_cmp++;
    if (wr_addr_q.size() != 12) begin
      n_bad++;
      $display("FAIL restart_cfg_count: %0d writes, required 12", wr_addr_q.size());
    end
    for (int i = 2; i < 12 && i < wr_addr_q.size(); i++) begin
      e = exp_cfg(i, tb_key, tb_iv);
      n_cmp++;
      if (wr_addr_q[i] !== e[39:32] || wr_data_q[i] !== e[31:0]) begin
        n_bad++;
        $display("FAIL restart_cfg %0d: addr %h data %h, required addr %h data %h",
                 i, wr_addr_q[i], wr_data_q[i], e[39:32], e[31:0]);
      end
    end
    k0 = kick_cnt;
    fill_random();
    push_expected(64'd0);
    send_block();
    receive_block(-1, 1'b0);
    n_cmp++;
    if (kick_cnt - k0 != 1 || last_kick !== 32'h1 || blk_cnt !== 32'd1) begin
      n_bad++;
      $display("FAIL restart_block: %0d kicks value %h blk_cnt %0d, required 1 00000001 1",
               kick_cnt - k0, last_kick, blk_cnt);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    cfg_start = 1'b0;
    cfg_key = 256'd0;
    cfg_iv = 64'd0;
    bus_if.in_valid = 1'b0;
    bus_if.in_data = 32'd0;
    bus_if.out_ready = 1'b1;
    test_reset();
    test_config();
    test_known_answer();
    test_second_block();
    test_backpressure();
    test_ignored_inputs();
    test_reset_mid_drain();
    test_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
